// File: rtl/uart_pkg.sv
// Shared definitions for the oversampling UART receiver: parity modes,
// receiver state encoding and divisor/width helpers.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_RECOVER
  } rxState_t;

  // Clocks per oversample tick, truncated.
  function automatic int calcDiv(input int clockRate, input int baudRate, input int oversample);
    return clockRate / (baudRate * oversample);
  endfunction

  // Bits needed to hold the values 0..n-1 (at least one bit).
  function automatic int cntWidth(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every DIV clocks, phase reset by
// a synchronous restart so ticks line up with the start edge of a frame.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int DIV = 78
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int W = cntWidth(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before the clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (restart) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == LAST) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + W'(1);
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: configurable 5-9 data bits, none/odd/even parity,
// 1 or 2 stop bits, majority-vote mid-bit sampling, framing/parity/break flags.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int CLOCK_RATE = 12000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rxEn,
  input  logic                 rxIn,
  output logic                 rxBusy,
  output logic                 rxDone,
  output logic                 rxErr,
  output logic                 rxParityErr,
  output logic                 rxBreak,
  output logic [DATA_BITS-1:0] rxOut
);

  localparam int DIV = calcDiv(CLOCK_RATE, BAUD_RATE, OVERSAMPLE);
  localparam int SW  = cntWidth(OVERSAMPLE);
  localparam int BW  = cntWidth(DATA_BITS + 1);

  localparam logic [SW-1:0] TICK_A   = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] TICK_B   = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] TICK_C   = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] TICK_END = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS);

  rxState_t             state;
  logic                 rxMeta, rxS;
  logic                 tick, baudRestart;
  logic [SW-1:0]        sampleCnt;
  logic [BW-1:0]        bitCnt;
  logic                 stopCnt;
  logic                 s0, s1;
  logic [DATA_BITS-1:0] dataSh;
  logic                 parBit;
  logic                 armed;
  logic                 recoverClr;
  logic                 vote, voteNow, bitEnd, parityBad;

  // Divider phase is held while idle, and while waiting out a low line in RECOVER.
  assign baudRestart = (state == S_IDLE) || (state == S_RECOVER && (!rxS || recoverClr));

  uart_baud_tick #(.DIV(DIV)) u_baudTick (
    .clk     (clk),
    .reset   (reset),
    .restart (baudRestart),
    .tick    (tick)
  );

  assign vote    = (s0 & s1) | (s0 & rxS) | (s1 & rxS);
  assign voteNow = tick && (sampleCnt == TICK_C);
  assign bitEnd  = tick && (sampleCnt == TICK_END);

  // NOTE: a default before the conditionals keeps this block free of latches.
  always_comb begin
    parityBad = 1'b0;
    if (PARITY == PAR_ODD)       parityBad = ~(^dataSh ^ parBit);
    else if (PARITY == PAR_EVEN) parityBad = ^dataSh ^ parBit;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxMeta <= 1'b1;
      rxS    <= 1'b1;
    end else begin
      rxMeta <= rxIn;
      rxS    <= rxMeta;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      rxBusy      <= 1'b0;
      rxDone      <= 1'b0;
      rxErr       <= 1'b0;
      rxParityErr <= 1'b0;
      rxBreak     <= 1'b0;
      rxOut       <= '0;
      sampleCnt   <= '0;
      bitCnt      <= '0;
      stopCnt     <= 1'b0;
      s0          <= 1'b1;
      s1          <= 1'b1;
      dataSh      <= '0;
      parBit      <= 1'b0;
      armed       <= 1'b0;
      recoverClr  <= 1'b0;
    end else begin
      rxDone      <= 1'b0;
      rxErr       <= 1'b0;
      rxParityErr <= 1'b0;
      rxBreak     <= 1'b0;
      recoverClr  <= 1'b0;
      // A start needs a falling edge seen while enabled, not just a low line.
      armed <= rxEn & (armed | rxS);

      if (tick && sampleCnt == TICK_A) s0 <= rxS;
      if (tick && sampleCnt == TICK_B) s1 <= rxS;
      if (tick) sampleCnt <= bitEnd ? '0 : sampleCnt + SW'(1);

      if (!rxEn) begin
        state  <= S_IDLE;
        rxBusy <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (armed && !rxS) begin
              state     <= S_START;
              rxBusy    <= 1'b1;
              sampleCnt <= '0;
              bitCnt    <= '0;
              stopCnt   <= 1'b0;
              parBit    <= 1'b0;
            end
          end
          S_START: begin
            if (voteNow && vote) begin
              state  <= S_IDLE;
              rxBusy <= 1'b0;
            end else if (bitEnd) begin
              state <= S_DATA;
            end
          end
          S_DATA: begin
            if (voteNow) begin
              dataSh <= {vote, dataSh[DATA_BITS-1:1]};
              bitCnt <= bitCnt + BW'(1);
            end
            if (bitEnd && bitCnt == LAST_BIT)
              state <= (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
          end
          S_PARITY: begin
            if (voteNow) parBit <= vote;
            if (bitEnd)  state  <= S_STOP;
          end
          S_STOP: begin
            if (voteNow) begin
              if (!vote) begin
                // Abort at the first low stop vote; an all-zero frame is a break.
                state      <= S_RECOVER;
                recoverClr <= 1'b1;
                sampleCnt  <= '0;
                if (dataSh == '0 && !parBit && !stopCnt) rxBreak <= 1'b1;
                else                                    rxErr   <= 1'b1;
              end else if (stopCnt == 1'(STOP_BITS - 1)) begin
                state       <= S_IDLE;
                rxBusy      <= 1'b0;
                rxDone      <= 1'b1;
                rxParityErr <= parityBad;
                rxOut       <= dataSh;
              end else begin
                stopCnt <= 1'b1;
              end
            end
          end
          S_RECOVER: begin
            if (!rxS) begin
              sampleCnt <= '0;
            end else if (bitEnd) begin
              state  <= S_IDLE;
              rxBusy <= 1'b0;
            end
          end
          default: begin
            state  <= S_IDLE;
            rxBusy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os: three receivers (default 8N1, fast 8N1,
// fast 7E2) share one line; only the enabled one is exercised at a time.
module tb_uart_rx_os;

  typedef enum int {EV_DONE, EV_ERR, EV_BREAK} evKind_t;
  typedef struct {
    evKind_t    kind;
    logic       parErr;
    logic [8:0] out;
  } expEv_t;

  logic clk = 1'b0;
  logic reset;
  logic rxIn;
  logic rxEnA, rxEnB, rxEnC;
  logic busyA, doneA, errA, parA, brkA;
  logic busyB, doneB, errB, parB, brkB;
  logic busyC, doneC, errC, parC, brkC;
  logic [7:0] outA, outB;
  logic [6:0] outC;

  int nDataOf  [3] = '{8, 8, 7};
  int parOf    [3] = '{0, 0, 2};
  int nStopOf  [3] = '{1, 1, 2};
  int bitClkOf [3] = '{1250, 96, 96};

  expEv_t     expQ[3][$];
  logic [8:0] lastOut[3];
  int nChecks = 0;
  int nPass   = 0;

  always #5 clk = ~clk;

  uart_rx_os u_dutA (
    .clk(clk), .reset(reset), .rxEn(rxEnA), .rxIn(rxIn), .rxBusy(busyA), .rxDone(doneA),
    .rxErr(errA), .rxParityErr(parA), .rxBreak(brkA), .rxOut(outA)
  );

  uart_rx_os #(.BAUD_RATE(115200)) u_dutB (
    .clk(clk), .reset(reset), .rxEn(rxEnB), .rxIn(rxIn), .rxBusy(busyB), .rxDone(doneB),
    .rxErr(errB), .rxParityErr(parB), .rxBreak(brkB), .rxOut(outB)
  );

  uart_rx_os #(.BAUD_RATE(115200), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_dutC (
    .clk(clk), .reset(reset), .rxEn(rxEnC), .rxIn(rxIn), .rxBusy(busyC), .rxDone(doneC),
    .rxErr(errC), .rxParityErr(parC), .rxBreak(brkC), .rxOut(outC)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual === expected) nPass++;
    else $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  function automatic logic busyOf(input int d);
    return (d == 0) ? busyA : (d == 1) ? busyB : busyC;
  endfunction

  // {done, err, break, parityErr}
  function automatic logic [3:0] pulsesOf(input int d);
    return (d == 0) ? {doneA, errA, brkA, parA} :
           (d == 1) ? {doneB, errB, brkB, parB} : {doneC, errC, brkC, parC};
  endfunction

  function automatic logic [8:0] outOf(input int d);
    return (d == 0) ? {1'b0, outA} : (d == 1) ? {1'b0, outB} : {2'b00, outC};
  endfunction

  // Frame outcome straight from the frame rules: first low stop bit decides.
  function automatic expEv_t predict(input int d, input logic [8:0] data, input logic parBit,
                                     input logic [1:0] stops);
    expEv_t e;
    logic   parUsed;
    parUsed  = (parOf[d] != 0) ? parBit : 1'b0;
    e.parErr = 1'b0;
    e.out    = lastOut[d];
    if (!stops[0]) begin
      e.kind = (data == 9'd0 && !parUsed) ? EV_BREAK : EV_ERR;
    end else if (nStopOf[d] == 2 && !stops[1]) begin
      e.kind = EV_ERR;
    end else begin
      e.kind = EV_DONE;
      e.out  = data;
      if (parOf[d] != 0)
        e.parErr = ((($countones(data) + int'(parBit)) % 2) == 1) != (parOf[d] == 1);
    end
    return e;
  endfunction

  task automatic monitorEvent(input int d, input logic [3:0] p, input logic [8:0] out);
    expEv_t  e;
    evKind_t k;
    check($sformatf("pulseOneHot[%0d]", d), $countones(p[3:1]), 1);
    check($sformatf("parityErrWithoutDone[%0d]", d), p[0] & ~p[3], 0);
    check($sformatf("eventExpected[%0d]", d), expQ[d].size() != 0, 1);
    if (expQ[d].size() != 0) begin
      e = expQ[d].pop_front();
      k = p[3] ? EV_DONE : p[2] ? EV_ERR : EV_BREAK;
      check($sformatf("eventKind[%0d]", d), k, e.kind);
      check($sformatf("rxParityErr[%0d]", d), p[0], e.parErr);
      check($sformatf("rxOut[%0d]", d), out, e.out);
    end
  endtask

  always @(negedge clk) begin
    if (reset)
      for (int d = 0; d < 3; d++)
        if (pulsesOf(d) != 4'b0) monitorEvent(d, pulsesOf(d), outOf(d));
  end

  // Drives one bit level and samples rxBusy at its middle.
  task automatic holdBit(input logic v, input int clks, input int d, output int miss);
    rxIn = v;
    repeat (clks / 2) @(negedge clk);
    miss = busyOf(d) ? 0 : 1;
    repeat (clks - clks / 2) @(negedge clk);
  endtask

  // A low stop bit is held for stopLowClk, then the line goes high and the
  // frame is abandoned (the receiver aborts at that vote).
  task automatic sendFrame(input int d, input logic [8:0] dataIn, input logic parBit,
                           input logic [1:0] stops, input int stopLowClk, input int gapBits);
    int         bc, miss, misses;
    logic [8:0] data;
    expEv_t     e;
    bc   = bitClkOf[d];
    data = dataIn & ((9'h1 << nDataOf[d]) - 9'h1);
    e    = predict(d, data, parBit, stops);
    expQ[d].push_back(e);
    lastOut[d] = e.out;
    misses = 0;
    holdBit(1'b0, bc, d, miss);
    misses += miss;
    for (int i = 0; i < nDataOf[d]; i++) begin
      holdBit(data[i], bc, d, miss);
      misses += miss;
    end
    if (parOf[d] != 0) begin
      holdBit(parBit, bc, d, miss);
      misses += miss;
    end
    for (int s = 0; s < nStopOf[d]; s++) begin
      if (stops[s]) begin
        holdBit(1'b1, bc, d, miss);
        misses += miss;
      end else begin
        rxIn = 1'b0;
        repeat (bc / 2) @(negedge clk);
        misses += busyOf(d) ? 0 : 1;
        repeat (stopLowClk - bc / 2) @(negedge clk);
        rxIn = 1'b1;
        break;
      end
    end
    check($sformatf("busyDuringFrame[%0d]", d), misses, 0);
    rxIn = 1'b1;
    repeat (gapBits * bc) @(negedge clk);
  endtask

  task automatic checkAllZero(input string name);
    for (int d = 0; d < 3; d++)
      check($sformatf("%s[%0d]", name, d), {pulsesOf(d), busyOf(d), outOf(d)}, 0);
  endtask

  initial begin
    logic [1:0] stops;
    // NOTE: inputs change on the falling edge with blocking assignments, so
    // the DUT never races the bench at the active edge.
    reset = 1'b0;
    rxIn  = 1'b1;
    rxEnA = 1'b0;
    rxEnB = 1'b0;
    rxEnC = 1'b0;
    for (int d = 0; d < 3; d++) lastOut[d] = 9'd0;
    repeat (5) @(negedge clk);
    checkAllZero("resetOutputs");
    reset = 1'b1;
    rxEnA = 1'b1;
    repeat (20) @(negedge clk);

    // Default 8N1 at 12 MHz / 9600: good frame, then framing error with recovery.
    sendFrame(0, 9'hB5, 1'b0, 2'b11, 0, 2);
    sendFrame(0, 9'hB5, 1'b0, 2'b10, 880, 0);
    repeat (1200) @(negedge clk);
    check("recoverStillBusy", busyA, 1'b1);
    repeat (100) @(negedge clk);
    check("recoverBackIdle", busyA, 1'b0);
    repeat (1250) @(negedge clk);

    rxEnA = 1'b0;
    rxEnB = 1'b1;
    repeat (20) @(negedge clk);

    // False start: a short low glitch starts then drops the frame.
    rxIn = 1'b0;
    repeat (10) @(negedge clk);
    check("glitchBusy", busyB, 1'b1);
    repeat (13) @(negedge clk);
    rxIn = 1'b1;
    repeat (67) @(negedge clk);
    check("glitchRejected", busyB, 1'b0);
    sendFrame(1, 9'h3C, 1'b0, 2'b11, 0, 2);

    // Break: line low for 12 bit times, then a clean frame.
    sendFrame(1, 9'h000, 1'b0, 2'b00, 3 * 96, 2);
    sendFrame(1, 9'hA5, 1'b0, 2'b11, 0, 2);

    for (int n = 0; n < 8; n++) begin
      stops = ($urandom_range(3) == 0) ? 2'b10 : 2'b11;
      sendFrame(1, 9'($urandom), 1'b0, stops, $urandom_range(96, 70), 2);
    end

    // Enable dropped mid-DATA.
    rxIn = 1'b0;
    repeat (96 + 3 * 96 + 20) @(negedge clk);
    check("busyBeforeDisable", busyB, 1'b1);
    rxEnB = 1'b0;
    @(negedge clk);
    check("disableIdlesNextCycle", busyB, 1'b0);
    rxIn = 1'b1;
    repeat (200) @(negedge clk);

    // Enable rising while the line is low must not start a frame.
    rxIn = 1'b0;
    repeat (20) @(negedge clk);
    rxEnB = 1'b1;
    repeat (300) @(negedge clk);
    check("lowEnableNoStart", busyB, 1'b0);
    rxIn = 1'b1;
    repeat (50) @(negedge clk);
    sendFrame(1, 9'h96, 1'b0, 2'b11, 0, 2);

    // Asynchronous reset mid-frame.
    rxIn = 1'b0;
    repeat (3 * 96) @(negedge clk);
    check("busyBeforeReset", busyB, 1'b1);
    reset = 1'b0;
    #1;
    checkAllZero("asyncResetOutputs");
    for (int d = 0; d < 3; d++) lastOut[d] = 9'd0;
    @(negedge clk);
    check("resetBusyNextCycle", busyB, 1'b0);
    rxIn = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    sendFrame(1, 9'h5A, 1'b0, 2'b11, 0, 2);

    // 7E2 receiver: good parity, bad parity, low second stop bit, then random.
    rxEnB = 1'b0;
    rxEnC = 1'b1;
    repeat (20) @(negedge clk);
    sendFrame(2, 9'h55, 1'b0, 2'b11, 0, 2);
    sendFrame(2, 9'h55, 1'b1, 2'b11, 0, 2);
    sendFrame(2, 9'h55, 1'b0, 2'b01, 70, 2);
    for (int n = 0; n < 6; n++) begin
      stops = ($urandom_range(3) == 0) ? 2'($urandom_range(2)) : 2'b11;
      sendFrame(2, 9'($urandom), 1'($urandom), stops, $urandom_range(96, 70), 2);
    end

    repeat (300) @(negedge clk);
    for (int d = 0; d < 3; d++)
      check($sformatf("pendingEvents[%0d]", d), expQ[d].size(), 0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
